// File: rtl/md5_compress.sv
// MD5 compression core: folds one padded 512-bit block into the chaining state.
// Ports: clk, rst (async active-low), start, first_block, block_in[0:511],
// digest[0:127], status (00 idle / 01 busy / 10 done), done (1-cycle pulse).
// Option: define MD5_UNROLL2_EN to allow ROUNDS_PER_CYCLE = 2 (32 round cycles).
module md5_compress #(
    parameter int ROUNDS_PER_CYCLE =
`ifdef MD5_UNROLL2_EN
        2
`else
        1
`endif
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         first_block,
    input  logic [0:511] block_in,
    output logic [0:127] digest,
    output logic [1:0]   status,
    output logic         done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_ROUND = 3'd2;
    localparam logic [2:0] S_FINAL = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [127:0] IV =
        128'h67452301_efcdab89_98badcfe_10325476;

    localparam logic [5:0] INC  = 6'(ROUNDS_PER_CYCLE);
    localparam logic [5:0] LAST = 6'(64 - ROUNDS_PER_CYCLE);

    localparam logic [31:0] K_TAB [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    // Indexed by {group, step mod 4}.
    localparam logic [4:0] S_TAB [16] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // One MD5 step on packed {a,b,c,d}.
    function automatic logic [127:0] md5_step(
        input logic [127:0] w,
        input logic [5:0]   i,
        input logic [0:511] m
    );
        logic [31:0] a, b, c, d, f, mw, sum, rot;
        logic [3:0]  g;
        logic [4:0]  s;
        {a, b, c, d} = w;
        f = '0;
        g = '0;
        unique case (i[5:4])
            2'd0: begin
                f = (b & c) | (~b & d);
                g = i[3:0];
            end
            2'd1: begin
                f = (d & b) | (~d & c);
                g = i[3:0] * 4'd5 + 4'd1;
            end
            2'd2: begin
                f = b ^ c ^ d;
                g = i[3:0] * 4'd3 + 4'd5;
            end
            default: begin
                f = c ^ (b | ~d);
                g = i[3:0] * 4'd7;
            end
        endcase
        s   = S_TAB[{i[5:4], i[1:0]}];
        // Block bytes arrive big-end first; message words are little-endian.
        mw  = bswap(m[{g, 5'd0} +: 32]);
        sum = a + f + K_TAB[i] + mw;
        rot = (sum << s) | (sum >> (6'd32 - {1'b0, s}));
        return {d, b + rot, b, c};
    endfunction

    logic [2:0]   state;
    logic [0:511] blk;
    logic         first_q;
    logic [127:0] chain;
    logic [127:0] work;
    logic [5:0]   step;
    logic [0:127] digest_q;
    logic [127:0] nxt;
    logic [127:0] fold;
    logic [0:127] fold_dig;

    always_comb begin
        nxt = md5_step(work, step, blk);
`ifdef MD5_UNROLL2_EN
        // Step counter is even here, so step|1 is the second step.
        if (ROUNDS_PER_CYCLE == 2)
            nxt = md5_step(nxt, step | 6'd1, blk);
`endif
    end

    assign fold = {chain[127:96] + work[127:96],
                   chain[95:64]  + work[95:64],
                   chain[63:32]  + work[63:32],
                   chain[31:0]   + work[31:0]};

    assign fold_dig = {bswap(fold[127:96]), bswap(fold[95:64]),
                       bswap(fold[63:32]),  bswap(fold[31:0])};

    // The new digest is shown during FINAL so it is valid alongside done.
    assign digest = (state == S_FINAL) ? fold_dig : digest_q;
    assign done   = (state == S_FINAL);
    assign status = (state == S_DONE) ? 2'b10 :
                    (state == S_IDLE) ? 2'b00 : 2'b01;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            blk      <= '0;
            first_q  <= 1'b0;
            chain    <= IV;
            work     <= '0;
            step     <= '0;
            digest_q <= '0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    // Capture on the start edge: block_in may move right after.
                    if (start) begin
                        blk     <= block_in;
                        first_q <= first_block;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (first_q) begin
                        chain <= IV;
                        work  <= IV;
                    end else begin
                        work  <= chain;
                    end
                    step  <= '0;
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    work <= nxt;
                    step <= step + INC;
                    if (step == LAST)
                        state <= S_FINAL;
                end
                S_FINAL: begin
                    chain    <= fold;
                    digest_q <= fold_dig;
                    state    <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/md5_compress.md
Name: md5_compress

Overview:
- Consumes one 512-bit padded block from md5_padding and runs the 64-step MD5 compression function on it.
- Folds the result into a 128-bit chaining state and presents the running digest.
- Sits directly downstream of md5_padding: padded_data feeds block_in.
- Multi-block messages are processed by issuing successive starts; first_block is set only on the first block.

Parameters:
- ROUNDS_PER_CYCLE, 1, MD5 steps evaluated per clock. Only 1 is legal without the optional feature.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse: capture block_in and begin compression
- first_block  input  1  sampled with start; 1 = load chaining state with the MD5 IV before compressing
- block_in  input  512  padded block, [0:511]; byte k = block_in[8k:8k+7]
- digest  output  128  [0:127]; standard MD5 byte order; digest[0:7] = low byte of A
- status  output  2  00 idle, 01 busy, 10 done (digest valid)
- done  output  1  one-cycle pulse when the digest updates

Behaviour:
- Reset (rst=0, asynchronous):
  - state = IDLE, status = 00, done = 0, digest = 0.
  - Chaining regs = IV: A=67452301, B=efcdab89, C=98badcfe, D=10325476.
  - Step counter = 0.
- Message words: M[j] = little-endian 32-bit word from bytes 4j..4j+3. Byte 4j is bits [7:0] of M[j].
- FSM states:
  - IDLE/DONE → LOAD on start.
  - LOAD → ROUND (1 cycle).
  - ROUND → ROUND while step < 63.
  - ROUND → FINAL at step 63.
  - FINAL → DONE (1 cycle).
- LOAD:
  - Latch block_in into the block register.
  - If first_block, chain ← IV.
  - Working a,b,c,d ← chain.
  - step ← 0.
- ROUND, step i:
  - F per group: i<16 (b&c)|(~b&d); i<32 (d&b)|(~d&c); i<48 b^c^d; else c^(b|~d).
  - g = i, (5i+1) mod 16, (3i+5) mod 16, (7i) mod 16 for the same four groups.
  - Rotate amounts: 7,12,17,22 / 5,9,14,20 / 4,11,16,23 / 6,10,15,21.
  - K[i] = floor(|sin(i+1)|·2^32), held as a constant table.
  - Update: a←d, d←c, c←b, b←b+rotl(a+F+K[i]+M[g], s[i]).
  - All adds are mod 2^32, no carry out.
- FINAL:
  - chain ← chain + working regs, per word, mod 2^32.
  - digest ← byte-swapped concatenation of A,B,C,D.
  - done = 1 for this cycle only.
- DONE: status = 10; digest holds until the next FINAL or reset.
- Latency: start at cycle 0 → done asserted at cycle 66 (LOAD 1, ROUND 64, FINAL 1). status = 01 from cycle 1 to cycle 66.
- Start handling:
  - start while status = 01 is ignored; no restart, no corruption.
  - start in DONE begins a new block; digest keeps its old value until the new FINAL.
- first_block is only meaningful with start; it is ignored at all other times.
- block_in may change after the start cycle; it is latched at LOAD.
- Reset mid-operation aborts immediately to the reset state. No done pulse occurs.

Optional Feature:
- Macro: MD5_UNROLL2_EN.
- Defined:
  - ROUNDS_PER_CYCLE = 2 is legal; two chained MD5 steps are evaluated per cycle.
  - ROUND runs 32 cycles; done arrives at cycle 34.
  - Digest is bit-identical to the single-step build.
- Undefined: one step per cycle, latency 66.

Test Plan:
1. "abc" block with first_block = 1:
   - Stimulus: bytes 61 62 63 80, zeros, byte56 = 18, bytes 57..63 = 0.
   - Required: digest = 900150983cd24fb0d6963f7d28e17f72; done exactly at cycle 66; status 01→10.
2. Empty message, first_block = 1:
   - Stimulus: byte0 = 80, all other bytes 0 (length 0).
   - Required: digest = d41d8cd98f00b204e9800998ecf8427e.
3. 60-byte "AAAAAAAAAABBBBBBBBBBCCCCCCCCCCDDDDDDDDDDEEEEEEEEEEFFFFFFFFFF":
   - Stimulus: two blocks from md5_padding; first_block = 1 then 0; second start issued after the first done.
   - Required: digest equals the software MD5 of the 60-byte string. The intermediate digest after block 1 must differ from the final digest.
4. Start pulsed at cycles 10 and 40 of a busy compression:
   - Required: ignored; done still at cycle 66 with the test-1 digest.
5. rst driven low at step 30, then released, then the "abc" block started again:
   - Required: during reset, status = 00 and digest = 0; no done pulse from the aborted run.
   - After release and the "abc" restart, digest = 900150983cd24fb0d6963f7d28e17f72.
6. With MD5_UNROLL2_EN defined, repeat tests 1 and 2:
   - Required: same digests; done at cycle 34.
